param_cache: RTL and testbench
==============================

Name: param_cache

Overview:
- Parametrised primitive-parameter cache for the PVR ISP/TSP pipeline.
- Each entry holds one packed primitive: ISP/TSP/TCW header plus NUM_VERTS vertex records. Storage is indexed by prim_tag.
- Adds per-entry valid tracking, hit/miss reporting, a read request/ack handshake, write-to-read bypass, out-of-range tag detection, and a sweeping clear engine.
- Sits between the primitive fetcher (writer) and the rasteriser/TSP setup (reader).

Parameters:
- ENTRIES, 512, number of cache entries; power of two, at least 2.
- TAG_W, 12, tag port width; at least $clog2(ENTRIES).
- HDR_W, 96, packed header width (isp, tsp, tcw words, 32 bits each).
- VERT_W, 304, packed vertex width (x, y, z, u0, v0 at 48 bits each; base_col_0, off_col at 32 bits each).
- NUM_VERTS, 3, vertices per entry; 3 for triangles, 4 for quads/sprites.
- Derived: ENTRY_W = HDR_W + NUM_VERTS*VERT_W. Header occupies the LSBs, then vertex A, B, C, and D if present.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  pulse; invalidate all entries
- busy  out  1  clear sweep in progress
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_tag  in  TAG_W  write index
- wr_data  in  ENTRY_W  packed primitive
- rd_req  in  1  read request
- rd_tag  in  TAG_W  read index
- rd_ack  out  1  read result valid (one-cycle pulse)
- rd_hit  out  1  entry was valid
- rd_data  out  ENTRY_W  packed primitive
- err_oor  out  1  pulse; tag >= ENTRIES seen on an accepted write or a read
- occupancy  out  $clog2(ENTRIES)+1  count of valid entries

Behaviour:
- Storage:
  - Data array is inferred synchronous RAM (ENTRIES x ENTRY_W) and is not reset.
  - Valid array is ENTRIES flops.
  - Only the valid bits define cache content.
- FSM states: IDLE, CLEAR.
  - Reset forces CLEAR with sweep_idx=0.
  - IDLE -> CLEAR when clear=1; sweep_idx loads 0.
  - In CLEAR, one valid bit (sweep_idx) is cleared per cycle and sweep_idx increments.
  - The cycle after sweep_idx=ENTRIES-1 is cleared, state returns to IDLE.
  - A full sweep is exactly ENTRIES cycles.
  - clear=1 while in CLEAR restarts the sweep at 0.
- busy = (state==CLEAR), registered.
- occupancy is forced to 0 on reset and on every entry into CLEAR (including a restart).
- Reset values: busy=1, rd_ack=0, rd_hit=0, rd_data=0, err_oor=0, occupancy=0.
- wr_ready is combinational: (state==IDLE) && !clear. Clear wins over a same-cycle write.
- Accepted write, tag < ENTRIES:
  - data[tag] <= wr_data; valid[tag] <= 1.
  - occupancy increments only if valid[tag] was 0; an overwrite leaves it unchanged.
- Accepted write, tag >= ENTRIES: dropped; err_oor=1 next cycle.
- Read:
  - rd_req at cycle N gives rd_ack=1 at N+1. Latency is fixed at 1. There is no backpressure; a request may issue every cycle.
  - rd_hit = valid[rd_tag] as sampled at cycle N.
  - rd_data = data[rd_tag] on a hit; all zeros on a miss.
- Bypass: an accepted write and a read to the same in-range tag in the same cycle give rd_hit=1 and rd_data=wr_data. The read-after-write result is write-first.
- Read during busy: acked with rd_hit=0 and rd_data=0, even for an entry not yet swept.
- Read with rd_tag >= ENTRIES: rd_ack=1, rd_hit=0, rd_data=0, err_oor=1 at N+1.
- With no rd_req, rd_ack=0 and rd_hit/rd_data hold their last values.
- err_oor is the OR of the write and read conditions in the same cycle.
- Only tag bits [$clog2(ENTRIES)-1:0] index the arrays. The range check uses the full TAG_W.
- Reset mid-sweep or mid-read: all outputs return to their reset values on the next edge, the sweep restarts at 0, and any pending rd_ack is dropped.

Test Plan:
- Reset, then idle: busy=1 for exactly 512 cycles, then 0; occupancy=0; wr_ready=0 during busy and 1 afterwards.
- Write tag 5 with data D1; read tag 5 on the next cycle: rd_ack one cycle later, rd_hit=1, rd_data=D1, occupancy=1. Rewrite tag 5 with D2: occupancy stays 1, and a read returns D2.
- Read tag 7, never written: rd_ack=1, rd_hit=0, rd_data=0. In the same cycle, write tag 9 with D3 and read tag 9: rd_hit=1, rd_data=D3.
- Write tags 0..3, then pulse clear: occupancy=0 on the next cycle, busy=1 for 512 cycles, and a read of tag 2 during and after the sweep misses. clear and wr_valid in the same IDLE cycle: the write is not accepted.
- Write tag 0x200 (ENTRIES=512): write dropped, err_oor=1 one cycle later, occupancy unchanged. Read tag 0xFFF: rd_hit=0, err_oor=1.
- Back-to-back reads of tags 1, 2, 3 on consecutive cycles: three consecutive acks with matching data. Assert reset during the second ack: the third ack is suppressed and busy=1.
- Repeat the core scenarios with NUM_VERTS=4, ENTRIES=64: vertex D round-trips intact and the sweep lasts 64 cycles.

Source files
------------

// File: rtl/param_cache_if.sv
`timescale 1ns/1ps
// param_cache_if
//   Bus between the primitive fetcher / rasteriser side and param_cache.
//   master : the client (drives clear, write and read requests).
//   slave  : the cache (drives busy, wr_ready, read results, err_oor, occupancy).
//   Signals:
//     clear, busy                    - invalidate-all pulse and sweep status
//     wr_valid/wr_ready/wr_tag/wr_data - write channel (valid/ready)
//     rd_req/rd_tag                  - read request, no backpressure
//     rd_ack/rd_hit/rd_data          - read result, one cycle after rd_req
//     err_oor                        - out-of-range tag pulse
//     occupancy                      - number of valid entries
interface param_cache_if #(
    parameter int TAG_W   = 12,
    parameter int ENTRY_W = 1008,
    parameter int OCC_W   = 10
);
    logic               clear;
    logic               busy;
    logic               wr_valid;
    logic               wr_ready;
    logic [TAG_W-1:0]   wr_tag;
    logic [ENTRY_W-1:0] wr_data;
    logic               rd_req;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_ack;
    logic               rd_hit;
    logic [ENTRY_W-1:0] rd_data;
    logic               err_oor;
    logic [OCC_W-1:0]   occupancy;

    modport master (
        output clear, wr_valid, wr_tag, wr_data, rd_req, rd_tag,
        input  busy, wr_ready, rd_ack, rd_hit, rd_data, err_oor, occupancy
    );

    modport slave (
        input  clear, wr_valid, wr_tag, wr_data, rd_req, rd_tag,
        output busy, wr_ready, rd_ack, rd_hit, rd_data, err_oor, occupancy
    );
endinterface

// File: rtl/param_cache.sv
`timescale 1ns/1ps
// param_cache
//   Primitive-parameter cache indexed by prim_tag. Each entry holds one packed
//   primitive: header in the LSBs, then vertex A, B, C (and D when NUM_VERTS=4).
//   Data lives in an inferred synchronous RAM (not reset); per-entry valid bits
//   define what the cache holds. A clear (or reset) sweeps the valid bits one
//   per cycle, ENTRIES cycles in total, during which writes are refused and
//   reads miss.
//   Ports:
//     clock  - system clock
//     reset  - synchronous active-high reset
//     bus    - param_cache_if.slave (clear/busy, write channel, read channel,
//              err_oor, occupancy)
module param_cache #(
    parameter int ENTRIES   = 512,
    parameter int TAG_W     = 12,
    parameter int HDR_W     = 96,
    parameter int VERT_W    = 304,
    parameter int NUM_VERTS = 3
) (
    input  logic           clock,
    input  logic           reset,
    param_cache_if.slave   bus
);
    localparam int ENTRY_W = HDR_W + NUM_VERTS * VERT_W;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int OCC_W   = IDX_W + 1;
    // Range check is done on the full tag width, one bit wider so that
    // ENTRIES itself is representable even when TAG_W == IDX_W.
    localparam logic [TAG_W:0] ENTRIES_X = (TAG_W + 1)'(ENTRIES);

    typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;
    logic               rd_ack_q, rd_ack_d;
    logic               rd_hit_q, rd_hit_d;
    logic               err_oor_q, err_oor_d;

    logic [ENTRY_W-1:0] mem [ENTRIES];
    logic [ENTRY_W-1:0] ram_rdata_q;

    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               wr_in_range, rd_in_range;
    logic               busy, wr_ready, wr_fire, valid_set, bypass;
    logic               sweep_clr, occ_clr;

    assign wr_idx      = bus.wr_tag[IDX_W-1:0];
    assign rd_idx      = bus.rd_tag[IDX_W-1:0];
    assign wr_in_range = ({1'b0, bus.wr_tag} < ENTRIES_X);
    assign rd_in_range = ({1'b0, bus.rd_tag} < ENTRIES_X);

    assign busy      = (state_q == CLEAR);
    // A same-cycle clear takes priority over a write.
    assign wr_ready  = (state_q == IDLE) && !bus.clear;
    assign wr_fire   = bus.wr_valid && wr_ready;
    assign valid_set = wr_fire && wr_in_range;
    // Write-first forwarding when a read hits the entry being written.
    assign bypass    = valid_set && rd_in_range && (wr_idx == rd_idx);

    // ---------------- Sweep FSM ----------------
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        sweep_clr   = 1'b0;
        occ_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d     = CLEAR;
                    sweep_idx_d = '0;
                    occ_clr     = 1'b1;
                end
            end
            CLEAR: begin
                sweep_clr = 1'b1;
                if (bus.clear) begin
                    sweep_idx_d = '0;
                    occ_clr     = 1'b1;
                end else if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = IDLE;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // ---------------- Valid bits ----------------
    // Sweep clear and write set never coincide: writes are refused in CLEAR.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            assign valid_d[gi] = (sweep_clr && sweep_idx_q == IDX_W'(gi)) ? 1'b0 :
                                 (valid_set && wr_idx == IDX_W'(gi))      ? 1'b1 :
                                 valid_q[gi];
        end
    endgenerate

    // ---------------- Read / status next state ----------------
    always_comb begin
        rd_ack_d    = bus.rd_req;
        rd_hit_d    = rd_hit_q;
        err_oor_d   = (wr_fire && !wr_in_range) || (bus.rd_req && !rd_in_range);
        occupancy_d = occupancy_q;
        if (bus.rd_req) begin
            rd_hit_d = !busy && rd_in_range && (valid_q[rd_idx] || bypass);
        end
        if (occ_clr) begin
            occupancy_d = '0;
        end else if (valid_set && !valid_q[wr_idx]) begin
            occupancy_d = occupancy_q + OCC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR;
            sweep_idx_q <= '0;
            occupancy_q <= '0;
            rd_ack_q    <= 1'b0;
            rd_hit_q    <= 1'b0;
            err_oor_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            occupancy_q <= occupancy_d;
            rd_ack_q    <= rd_ack_d;
            rd_hit_q    <= rd_hit_d;
            err_oor_q   <= err_oor_d;
        end
    end

    // Valid bits need no reset: reset enters CLEAR, reads miss until the
    // sweep has cleared every bit.
    always_ff @(posedge clock) begin
        valid_q <= valid_d;
    end

    // ---------------- Data RAM ----------------
    // Output register only loads on a read so rd_data holds between requests.
    always_ff @(posedge clock) begin
        if (valid_set) begin
            mem[wr_idx] <= bus.wr_data;
        end
        if (bus.rd_req) begin
            ram_rdata_q <= bypass ? bus.wr_data : mem[rd_idx];
        end
    end

    // ---------------- Outputs ----------------
    assign bus.busy      = busy;
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_hit    = rd_hit_q;
    // A miss (or reset) masks the unreset RAM output register to zero.
    assign bus.rd_data   = rd_hit_q ? ram_rdata_q : '0;
    assign bus.err_oor   = err_oor_q;
    assign bus.occupancy = occupancy_q;

endmodule

// File: tb/tb_param_cache.sv
`timescale 1ns/1ps
// tb_param_cache
//   Directed bench for param_cache. Instance A: ENTRIES=512, NUM_VERTS=3.
//   Instance B: ENTRIES=64, NUM_VERTS=4. Inputs change 1ns after a rising
//   edge; outputs are sampled at the same point.
module tb_param_cache;
    localparam int WA = 96 + 3 * 304;   // 1008
    localparam int WB = 96 + 4 * 304;   // 1312

    logic clock;
    logic reset_a, reset_b;
    int   checks, errors;

    param_cache_if #(.TAG_W(12), .ENTRY_W(WA), .OCC_W(10)) bus_a ();
    param_cache_if #(.TAG_W(12), .ENTRY_W(WB), .OCC_W(7))  bus_b ();

    param_cache #(.ENTRIES(512), .TAG_W(12), .HDR_W(96), .VERT_W(304), .NUM_VERTS(3)) dut_a (
        .clock (clock),
        .reset (reset_a),
        .bus   (bus_a)
    );

    param_cache #(.ENTRIES(64), .TAG_W(12), .HDR_W(96), .VERT_W(304), .NUM_VERTS(4)) dut_b (
        .clock (clock),
        .reset (reset_b),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [WA-1:0]  d1, d2, d3, dz_a;
    logic [WA-1:0]  dt [4];
    logic [303:0]   vd;
    logic [WB-1:0]  dq, dq2, dz_b;

    function automatic logic [127:0] ends_a(input logic [WA-1:0] v);
        return {v[WA-1 -: 64], v[63:0]};
    endfunction

    function automatic logic [127:0] ends_b(input logic [WB-1:0] v);
        return {v[WB-1 -: 64], v[63:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        bus_a.clear = 0; bus_a.wr_valid = 0; bus_a.wr_tag = '0; bus_a.wr_data = '0;
        bus_a.rd_req = 0; bus_a.rd_tag = '0;
    endtask

    task automatic idle_b();
        bus_b.clear = 0; bus_b.wr_valid = 0; bus_b.wr_tag = '0; bus_b.wr_data = '0;
        bus_b.rd_req = 0; bus_b.rd_tag = '0;
    endtask

    // Counts consecutive busy samples starting at the current sample.
    task automatic wait_sweep_a(output int cnt);
        int guard;
        cnt = 0; guard = 0;
        while (bus_a.busy && guard < 1000) begin
            cnt++; tick(); guard++;
        end
        $display("sweep A: busy for %0d cycles", cnt);
    endtask

    task automatic wait_sweep_b(output int cnt);
        int guard;
        cnt = 0; guard = 0;
        while (bus_b.busy && guard < 1000) begin
            cnt++; tick(); guard++;
        end
        $display("sweep B: busy for %0d cycles", cnt);
    endtask

    task automatic test_reset();
        int cnt;
        idle_a();
        reset_a = 1;
        tick(); tick();
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus_a.busy); end
        checks++; if (bus_a.rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack: got %b expected 0", bus_a.rd_ack); end
        checks++; if (bus_a.rd_hit !== 1'b0) begin errors++; $display("FAIL reset_rd_hit: got %b expected 0", bus_a.rd_hit); end
        checks++; if (bus_a.rd_data !== dz_a) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", ends_a(bus_a.rd_data)); end
        checks++; if (bus_a.err_oor !== 1'b0) begin errors++; $display("FAIL reset_err_oor: got %b expected 0", bus_a.err_oor); end
        checks++; if (bus_a.occupancy !== 10'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", bus_a.occupancy); end
        checks++; if (bus_a.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", bus_a.wr_ready); end
        reset_a = 0;
        wait_sweep_a(cnt);
        checks++; if (cnt !== 512) begin errors++; $display("FAIL reset_sweep_len: got %0d expected 512", cnt); end
        checks++; if (bus_a.wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b expected 1", bus_a.wr_ready); end
        checks++; if (bus_a.occupancy !== 10'd0) begin errors++; $display("FAIL idle_occupancy: got %0d expected 0", bus_a.occupancy); end
    endtask

    task automatic test_write_read();
        bus_a.wr_valid = 1; bus_a.wr_tag = 12'd5; bus_a.wr_data = d1;
        tick();
        $display("write A tag 5 data %h", ends_a(d1));
        bus_a.wr_valid = 0; bus_a.rd_req = 1; bus_a.rd_tag = 12'd5;
        tick();
        bus_a.rd_req = 0;
        $display("read A tag 5 ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_ack !== 1'b1) begin errors++; $display("FAIL wr_rd_ack: got %b expected 1", bus_a.rd_ack); end
        checks++; if (bus_a.rd_hit !== 1'b1) begin errors++; $display("FAIL wr_rd_hit: got %b expected 1", bus_a.rd_hit); end
        checks++; if (bus_a.rd_data !== d1) begin errors++; $display("FAIL wr_rd_data: got %h expected %h", ends_a(bus_a.rd_data), ends_a(d1)); end
        checks++; if (bus_a.occupancy !== 10'd1) begin errors++; $display("FAIL wr_occupancy: got %0d expected 1", bus_a.occupancy); end
        // Overwrite: occupancy unchanged, read outputs hold while no request.
        bus_a.wr_valid = 1; bus_a.wr_tag = 12'd5; bus_a.wr_data = d2;
        tick();
        $display("write A tag 5 data %h", ends_a(d2));
        bus_a.wr_valid = 0;
        checks++; if (bus_a.occupancy !== 10'd1) begin errors++; $display("FAIL rewrite_occupancy: got %0d expected 1", bus_a.occupancy); end
        checks++; if (bus_a.rd_ack !== 1'b0) begin errors++; $display("FAIL noreq_rd_ack: got %b expected 0", bus_a.rd_ack); end
        checks++; if (bus_a.rd_data !== d1) begin errors++; $display("FAIL hold_rd_data: got %h expected %h", ends_a(bus_a.rd_data), ends_a(d1)); end
        bus_a.rd_req = 1; bus_a.rd_tag = 12'd5;
        tick();
        bus_a.rd_req = 0;
        $display("read A tag 5 ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_data !== d2) begin errors++; $display("FAIL rewrite_rd_data: got %h expected %h", ends_a(bus_a.rd_data), ends_a(d2)); end
    endtask

    task automatic test_miss_bypass();
        bus_a.rd_req = 1; bus_a.rd_tag = 12'd7;
        tick();
        $display("read A tag 7 ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_ack !== 1'b1) begin errors++; $display("FAIL miss_rd_ack: got %b expected 1", bus_a.rd_ack); end
        checks++; if (bus_a.rd_hit !== 1'b0) begin errors++; $display("FAIL miss_rd_hit: got %b expected 0", bus_a.rd_hit); end
        checks++; if (bus_a.rd_data !== dz_a) begin errors++; $display("FAIL miss_rd_data: got %h expected 0", ends_a(bus_a.rd_data)); end
        bus_a.wr_valid = 1; bus_a.wr_tag = 12'd9; bus_a.wr_data = d3; bus_a.rd_tag = 12'd9;
        tick();
        idle_a();
        $display("write+read A tag 9 ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_hit !== 1'b1) begin errors++; $display("FAIL bypass_rd_hit: got %b expected 1", bus_a.rd_hit); end
        checks++; if (bus_a.rd_data !== d3) begin errors++; $display("FAIL bypass_rd_data: got %h expected %h", ends_a(bus_a.rd_data), ends_a(d3)); end
        checks++; if (bus_a.occupancy !== 10'd2) begin errors++; $display("FAIL bypass_occupancy: got %0d expected 2", bus_a.occupancy); end
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 0; i < 4; i++) begin
            bus_a.wr_valid = 1; bus_a.wr_tag = 12'(i); bus_a.wr_data = dt[i];
            tick();
            $display("write A tag %0d data %h", i, ends_a(dt[i]));
        end
        idle_a();
        checks++; if (bus_a.occupancy !== 10'd6) begin errors++; $display("FAIL clear_pre_occupancy: got %0d expected 6", bus_a.occupancy); end
        // clear and a write in the same IDLE cycle: write refused.
        bus_a.clear = 1; bus_a.wr_valid = 1; bus_a.wr_tag = 12'd10; bus_a.wr_data = d1;
        #1;
        checks++; if (bus_a.wr_ready !== 1'b0) begin errors++; $display("FAIL clear_wr_ready: got %b expected 0", bus_a.wr_ready); end
        tick();
        idle_a();
        checks++; if (bus_a.occupancy !== 10'd0) begin errors++; $display("FAIL clear_occupancy: got %0d expected 0", bus_a.occupancy); end
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL clear_busy: got %b expected 1", bus_a.busy); end
        bus_a.rd_req = 1; bus_a.rd_tag = 12'd2;
        tick();
        bus_a.rd_req = 0;
        $display("read A tag 2 (sweeping) ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_ack !== 1'b1 || bus_a.rd_hit !== 1'b0) begin errors++; $display("FAIL busy_read: got ack=%b hit=%b expected ack=1 hit=0", bus_a.rd_ack, bus_a.rd_hit); end
        checks++; if (bus_a.rd_data !== dz_a) begin errors++; $display("FAIL busy_rd_data: got %h expected 0", ends_a(bus_a.rd_data)); end
        wait_sweep_a(cnt);
        checks++; if (cnt + 1 !== 512) begin errors++; $display("FAIL clear_sweep_len: got %0d expected 512", cnt + 1); end
        bus_a.rd_req = 1; bus_a.rd_tag = 12'd2;
        tick();
        $display("read A tag 2 ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_hit !== 1'b0) begin errors++; $display("FAIL post_clear_hit: got %b expected 0", bus_a.rd_hit); end
        bus_a.rd_tag = 12'd10;
        tick();
        bus_a.rd_req = 0;
        $display("read A tag 10 ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_hit !== 1'b0) begin errors++; $display("FAIL refused_write_hit: got %b expected 0", bus_a.rd_hit); end
        checks++; if (bus_a.occupancy !== 10'd0) begin errors++; $display("FAIL post_clear_occupancy: got %0d expected 0", bus_a.occupancy); end
    endtask

    task automatic test_oor();
        bus_a.wr_valid = 1; bus_a.wr_tag = 12'h200; bus_a.wr_data = d1;
        #1;
        checks++; if (bus_a.wr_ready !== 1'b1) begin errors++; $display("FAIL oor_wr_ready: got %b expected 1", bus_a.wr_ready); end
        tick();
        idle_a();
        $display("write A tag 0x200 err_oor=%b", bus_a.err_oor);
        checks++; if (bus_a.err_oor !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", bus_a.err_oor); end
        checks++; if (bus_a.occupancy !== 10'd0) begin errors++; $display("FAIL oor_occupancy: got %0d expected 0", bus_a.occupancy); end
        tick();
        checks++; if (bus_a.err_oor !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b expected 0", bus_a.err_oor); end
        bus_a.rd_req = 1; bus_a.rd_tag = 12'hFFF;
        tick();
        $display("read A tag 0xFFF ack=%b hit=%b err_oor=%b", bus_a.rd_ack, bus_a.rd_hit, bus_a.err_oor);
        checks++; if (bus_a.rd_ack !== 1'b1 || bus_a.rd_hit !== 1'b0) begin errors++; $display("FAIL oor_read: got ack=%b hit=%b expected ack=1 hit=0", bus_a.rd_ack, bus_a.rd_hit); end
        checks++; if (bus_a.err_oor !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", bus_a.err_oor); end
        checks++; if (bus_a.rd_data !== dz_a) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", ends_a(bus_a.rd_data)); end
        // Tag 0x200 aliases index 0 in the low bits; the dropped write must not land there.
        bus_a.rd_tag = 12'd0;
        tick();
        bus_a.rd_req = 0;
        $display("read A tag 0 ack=%b hit=%b", bus_a.rd_ack, bus_a.rd_hit);
        checks++; if (bus_a.rd_hit !== 1'b0) begin errors++; $display("FAIL oor_alias_hit: got %b expected 0", bus_a.rd_hit); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        for (int i = 1; i < 4; i++) begin
            bus_a.wr_valid = 1; bus_a.wr_tag = 12'(i); bus_a.wr_data = dt[i];
            tick();
            $display("write A tag %0d data %h", i, ends_a(dt[i]));
        end
        idle_a();
        checks++; if (bus_a.occupancy !== 10'd3) begin errors++; $display("FAIL b2b_occupancy: got %0d expected 3", bus_a.occupancy); end
        for (int i = 1; i < 4; i++) begin
            bus_a.rd_req = 1; bus_a.rd_tag = 12'(i);
            tick();
            $display("read A tag %0d ack=%b hit=%b", i, bus_a.rd_ack, bus_a.rd_hit);
            checks++;
            if (bus_a.rd_ack !== 1'b1 || bus_a.rd_hit !== 1'b1 || bus_a.rd_data !== dt[i]) begin
                errors++;
                $display("FAIL b2b_read_%0d: got ack=%b hit=%b data=%h expected ack=1 hit=1 data=%h",
                         i, bus_a.rd_ack, bus_a.rd_hit, ends_a(bus_a.rd_data), ends_a(dt[i]));
            end
        end
        // Replay, asserting reset while the second ack is showing.
        bus_a.rd_tag = 12'd1; tick();
        bus_a.rd_tag = 12'd2; tick();
        $display("read A tag 2 ack=%b hit=%b (reset next)", bus_a.rd_ack, bus_a.rd_hit);
        reset_a = 1; bus_a.rd_tag = 12'd3;
        tick();
        reset_a = 0; bus_a.rd_req = 0;
        checks++; if (bus_a.rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack_drop: got %b expected 0", bus_a.rd_ack); end
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy: got %b expected 1", bus_a.busy); end
        checks++; if (bus_a.rd_data !== dz_a) begin errors++; $display("FAIL reset_mid_data: got %h expected 0", ends_a(bus_a.rd_data)); end
        checks++; if (bus_a.occupancy !== 10'd0) begin errors++; $display("FAIL reset_mid_occupancy: got %0d expected 0", bus_a.occupancy); end
        wait_sweep_a(cnt);
        checks++; if (cnt !== 512) begin errors++; $display("FAIL reset_mid_sweep_len: got %0d expected 512", cnt); end
    endtask

    task automatic test_quad_config();
        int cnt;
        idle_b();
        reset_b = 1;
        tick();
        reset_b = 0;
        wait_sweep_b(cnt);
        checks++; if (cnt !== 64) begin errors++; $display("FAIL quad_reset_sweep_len: got %0d expected 64", cnt); end
        bus_b.wr_valid = 1; bus_b.wr_tag = 12'd5; bus_b.wr_data = dq;
        tick();
        $display("write B tag 5 data %h", ends_b(dq));
        bus_b.wr_valid = 0; bus_b.rd_req = 1; bus_b.rd_tag = 12'd5;
        tick();
        bus_b.rd_req = 0;
        $display("read B tag 5 ack=%b hit=%b", bus_b.rd_ack, bus_b.rd_hit);
        checks++; if (bus_b.rd_hit !== 1'b1 || bus_b.rd_data !== dq) begin errors++; $display("FAIL quad_rd: got hit=%b data=%h expected hit=1 data=%h", bus_b.rd_hit, ends_b(bus_b.rd_data), ends_b(dq)); end
        checks++; if (bus_b.rd_data[WB-1 -: 304] !== vd) begin errors++; $display("FAIL quad_vertex_d: got %h expected %h", bus_b.rd_data[WB-1 -: 64], vd[303 -: 64]); end
        bus_b.wr_valid = 1; bus_b.wr_tag = 12'd9; bus_b.wr_data = dq2; bus_b.rd_req = 1; bus_b.rd_tag = 12'd9;
        tick();
        idle_b();
        $display("write+read B tag 9 ack=%b hit=%b", bus_b.rd_ack, bus_b.rd_hit);
        checks++; if (bus_b.rd_hit !== 1'b1 || bus_b.rd_data !== dq2) begin errors++; $display("FAIL quad_bypass: got hit=%b data=%h expected hit=1 data=%h", bus_b.rd_hit, ends_b(bus_b.rd_data), ends_b(dq2)); end
        bus_b.wr_valid = 1; bus_b.wr_tag = 12'd64; bus_b.wr_data = dq;
        tick();
        idle_b();
        $display("write B tag 64 err_oor=%b", bus_b.err_oor);
        checks++; if (bus_b.err_oor !== 1'b1) begin errors++; $display("FAIL quad_oor_err: got %b expected 1", bus_b.err_oor); end
        checks++; if (bus_b.occupancy !== 7'd2) begin errors++; $display("FAIL quad_occupancy: got %0d expected 2", bus_b.occupancy); end
        // Clear, then restart the sweep part-way through.
        bus_b.clear = 1;
        tick();
        bus_b.clear = 0;
        checks++; if (bus_b.occupancy !== 7'd0 || bus_b.busy !== 1'b1) begin errors++; $display("FAIL quad_clear: got occ=%0d busy=%b expected occ=0 busy=1", bus_b.occupancy, bus_b.busy); end
        repeat (10) tick();
        bus_b.clear = 1;
        tick();
        bus_b.clear = 0;
        wait_sweep_b(cnt);
        checks++; if (cnt !== 64) begin errors++; $display("FAIL quad_restart_sweep_len: got %0d expected 64", cnt); end
        bus_b.rd_req = 1; bus_b.rd_tag = 12'd5;
        tick();
        bus_b.rd_req = 0;
        $display("read B tag 5 ack=%b hit=%b", bus_b.rd_ack, bus_b.rd_hit);
        checks++; if (bus_b.rd_ack !== 1'b1 || bus_b.rd_hit !== 1'b0) begin errors++; $display("FAIL quad_post_clear: got ack=%b hit=%b expected ack=1 hit=0", bus_b.rd_ack, bus_b.rd_hit); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0;
        d1   = {84{12'hA51}};
        d2   = {126{8'h3C}};
        d3   = {63{16'hBEEF}};
        dz_a = '0;
        for (int i = 0; i < 4; i++) dt[i] = {126{8'(8'h10 + i)}};
        vd   = {38{8'hDD}};
        dq   = {vd, d1};
        dq2  = {{38{8'h77}}, d2};
        dz_b = '0;
        reset_a = 1; reset_b = 1;
        idle_a(); idle_b();
        test_reset();
        test_write_read();
        test_miss_bypass();
        test_clear();
        test_oor();
        test_back_to_back();
        test_quad_config();
        checks++; if (bus_b.rd_data !== dz_b) begin errors++; $display("FAIL quad_miss_data: got %h expected 0", ends_b(bus_b.rd_data)); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
